hazard_ctrl: RTL and testbench

Pipeline hazard controller for the vector ASIP datapath. Tracks destination registers of instructions in EX, MEM and WB and computes per-operand forwarding selects for the ALU forwarding mux. Stalls IF/ID and injects bubbles for load-use hazards and multi-cycle vector ops, and flushes on taken branches. Sits beside the ID/EX pipeline register and drives the ALU forwarding unit's operand selects.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/hazard_tracker.sv | 23 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, VBUSY, FLUSH} ctrl_state_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             we;
    logic             load;
  } stage_slot_t;
  function automatic logic hits(input stage_slot_t s, input logic [REG_W-1:0] r, input logic used);
    return used & s.valid & s.we & (s.dest == r);
  endfunction
endpackage

// File: rtl/hazard_tracker.sv
// hazard_tracker: EX/MEM/WB destination shift register with freeze and bubble insertion
module hazard_tracker import pipe_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        bubble,
  input  stage_slot_t id_slot,
  output stage_slot_t ex,
  output stage_slot_t mem,
  output stage_slot_t wb
);
  // a frozen EX holds its op and feeds MEM a hole; a bubble always wins over freeze
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= bubble ? '0 : freeze ? ex : id_slot;
      mem <= freeze ? '0 : ex;
      wb  <= mem;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush control and ALU operand forwarding selects (FORWARDING_EN enables forwarding)
module hazard_ctrl #(
  parameter int VEC_LAT = 4,
  parameter int REG_W   = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_r2,
  input  logic [REG_W-1:0] id_r3,
  input  logic             id_use_r2,
  input  logic             id_imm,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             id_vmul,
  input  logic             br_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_r2,
  output logic [1:0]       fwd_r3
);
  import pipe_ctrl_pkg::*;
  ctrl_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  stage_slot_t ex, mem, wb;
  logic use2, use3, ex2, ex3, mem2, mem3, ld_use, hz, vbusy, stall, freeze, unused_wb;
  assign use2   = id_valid & id_use_r2;
  assign use3   = id_valid & !id_imm;
  assign ex2    = hits(ex, id_r2, use2);
  assign ex3    = hits(ex, id_r3, use3);
  assign mem2   = hits(mem, id_r2, use2);
  assign mem3   = hits(mem, id_r3, use3);
  assign ld_use = (ex2 | ex3) & ex.load;
`ifdef FORWARDING_EN
  assign hz = ld_use;
`else
  assign hz = ld_use | ex2 | ex3 | mem2 | mem3;
`endif
  assign vbusy     = state == VBUSY;
  assign freeze    = vbusy & !br_taken;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign unused_wb = ^wb;
  hazard_tracker u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .freeze  (freeze),
    .bubble  (bubble_ex),
    .id_slot ('{valid: id_valid, dest: id_dest, we: id_we, load: id_load}),
    .ex      (ex),
    .mem     (mem),
    .wb      (wb)
  );
  // control state and vector-op occupancy counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // branch flush beats everything, then vector busy, then data hazard, else issue
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stall     = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (br_taken) begin
      state_nx  = FLUSH;
      cnt_nx    = '0;
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (vbusy) begin
      stall    = 1'b1;
      cnt_nx   = cnt - CNT_W'(1);
      state_nx = cnt == CNT_W'(1) ? RUN : VBUSY;
    end else if (hz) begin
      state_nx  = RUN;
      stall     = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      state_nx = id_valid & id_vmul ? VBUSY : RUN;
      cnt_nx   = id_valid & id_vmul ? CNT_W'(VEC_LAT - 1) : '0;
    end
  end
`ifdef FORWARDING_EN
  fwd_sel_t f2, f3;
  // operand selects follow the instruction into EX; bubbles read the register file
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f2 <= FWD_RF;
      f3 <= FWD_RF;
    end else if (!freeze) begin
      f2 <= bubble_ex ? FWD_RF : ex2 ? FWD_EXMEM : mem2 ? FWD_MEMWB : FWD_RF;
      f3 <= bubble_ex ? FWD_RF : ex3 ? FWD_EXMEM : mem3 ? FWD_MEMWB : FWD_RF;
    end
  assign fwd_r2 = f2;
  assign fwd_r3 = f3;
`else
  assign fwd_r2 = FWD_RF;
  assign fwd_r3 = FWD_RF;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 0, id_use_r2 = 0, id_imm = 0, id_we = 0, id_load = 0, id_vmul = 0, br_taken = 0;
  logic [3:0] id_r2 = 0, id_r3 = 0, id_dest = 0;
  logic stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0] fwd_r2, fwd_r3;
  int vecs = 0, errs = 0;
  wire [3:0] ctl = {stall_if, stall_id, bubble_ex, flush_id};
  wire [3:0] fwd = {fwd_r2, fwd_r3};

  always #5 clk = ~clk;

  hazard_ctrl #(.VEC_LAT(4), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r2(id_r2), .id_r3(id_r3),
    .id_use_r2(id_use_r2), .id_imm(id_imm), .id_dest(id_dest), .id_we(id_we),
    .id_load(id_load), .id_vmul(id_vmul), .br_taken(br_taken), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_r2(fwd_r2), .fwd_r3(fwd_r3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] r2, input logic [3:0] r3, input logic u2,
                        input logic imm, input logic [3:0] d, input logic we, input logic ld, input logic vm);
    id_valid = v; id_r2 = r2; id_r3 = r3; id_use_r2 = u2; id_imm = imm;
    id_dest = d; id_we = we; id_load = ld; id_vmul = vm;
    #1;
  endtask

  task automatic drain;
    br_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick;
  endtask

  task automatic test_reset;
    set_id(1, 5, 5, 1, 0, 5, 1, 1, 1);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL reset_ctl: got %b want %b", ctl, 4'b0000); end
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL reset_fwd: got %b want %b", fwd, 4'b0000); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    drain;
    set_id(1, 1, 2, 1, 0, 5, 1, 0, 0);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL b2b_prod: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(1, 5, 3, 1, 0, 7, 1, 0, 0);
`ifdef FORWARDING_EN
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL b2b_nostall: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0100) begin errs++; $display("FAIL b2b_fwd: got %b want %b", fwd, 4'b0100); end
`else
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL b2b_stall_ex: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL b2b_stall_mem: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL b2b_release: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL b2b_fwd: got %b want %b", fwd, 4'b0000); end
`endif
  endtask

  task automatic test_mem_fwd;
    drain;
    set_id(1, 1, 2, 1, 0, 5, 1, 0, 0);
    tick;
    set_id(1, 1, 2, 1, 0, 9, 1, 0, 0);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL mem_unrel: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(1, 5, 3, 1, 0, 7, 1, 0, 0);
`ifdef FORWARDING_EN
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL mem_nostall: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b1000) begin errs++; $display("FAIL mem_fwd_r2: got %b want %b", fwd, 4'b1000); end
`else
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL mem_stall: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL mem_release: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL mem_fwd_r2: got %b want %b", fwd, 4'b0000); end
`endif
    drain;
    set_id(1, 0, 0, 0, 1, 6, 1, 0, 0);
    tick;
    set_id(1, 0, 0, 0, 1, 6, 1, 0, 0);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL dual_prod: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(1, 0, 6, 0, 0, 7, 1, 0, 0);
`ifdef FORWARDING_EN
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL dual_nostall: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0001) begin errs++; $display("FAIL dual_fwd_r3: got %b want %b", fwd, 4'b0001); end
`else
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL dual_stall_ex: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL dual_stall_mem: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL dual_release: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL dual_fwd_r3: got %b want %b", fwd, 4'b0000); end
`endif
  endtask

  task automatic test_imm;
    drain;
    set_id(1, 0, 0, 0, 1, 6, 1, 0, 0);
    tick;
    set_id(1, 6, 6, 0, 1, 7, 1, 0, 0);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL imm_nostall: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL imm_fwd: got %b want %b", fwd, 4'b0000); end
  endtask

  task automatic test_load_use;
    drain;
    set_id(1, 0, 0, 0, 1, 4, 1, 1, 0);
    tick;
    set_id(1, 4, 0, 1, 1, 7, 1, 0, 0);
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL ld_bubble: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL ld_bubble_fwd: got %b want %b", fwd, 4'b0000); end
`ifdef FORWARDING_EN
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL ld_release: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b1000) begin errs++; $display("FAIL ld_fwd_r2: got %b want %b", fwd, 4'b1000); end
`else
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL ld_stall2: got %b want %b", ctl, 4'b1110); end
    tick;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL ld_release: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL ld_fwd_r2: got %b want %b", fwd, 4'b0000); end
`endif
  endtask

  task automatic test_vmul;
    drain;
    set_id(1, 0, 0, 0, 1, 8, 1, 0, 1);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL vmul_issue: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(1, 1, 0, 1, 1, 10, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vecs++; if (ctl !== 4'b1100) begin errs++; $display("FAIL vmul_busy%0d: got %b want %b", i, ctl, 4'b1100); end
      tick;
    end
    set_id(1, 8, 0, 1, 1, 10, 1, 0, 0);
`ifdef FORWARDING_EN
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL vmul_done: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0100) begin errs++; $display("FAIL vmul_fwd: got %b want %b", fwd, 4'b0100); end
`else
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL vmul_done: got %b want %b", ctl, 4'b1110); end
`endif
  endtask

  task automatic test_branch;
    drain;
    set_id(1, 0, 0, 0, 1, 8, 1, 0, 1);
    tick;
    set_id(1, 1, 0, 1, 1, 10, 1, 0, 0);
    vecs++; if (ctl !== 4'b1100) begin errs++; $display("FAIL br_busy: got %b want %b", ctl, 4'b1100); end
    tick;
    br_taken = 1;
    #1;
    vecs++; if (ctl !== 4'b0011) begin errs++; $display("FAIL br_flush: got %b want %b", ctl, 4'b0011); end
    tick;
    br_taken = 0;
    #1;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL br_after: got %b want %b", ctl, 4'b0000); end
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL br_fwd: got %b want %b", fwd, 4'b0000); end
    tick;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL br_run: got %b want %b", ctl, 4'b0000); end
  endtask

  task automatic test_load_vmul;
    drain;
    set_id(1, 0, 0, 0, 1, 4, 1, 1, 0);
    tick;
    set_id(1, 4, 0, 1, 1, 9, 1, 0, 1);
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL lv_stall: got %b want %b", ctl, 4'b1110); end
    tick;
`ifndef FORWARDING_EN
    vecs++; if (ctl !== 4'b1110) begin errs++; $display("FAIL lv_stall2: got %b want %b", ctl, 4'b1110); end
    tick;
`endif
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL lv_issue: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (ctl !== 4'b1100) begin errs++; $display("FAIL lv_busy: got %b want %b", ctl, 4'b1100); end
  endtask

  task automatic test_reset_mid;
    drain;
    set_id(1, 0, 0, 0, 1, 8, 1, 0, 1);
    tick;
    vecs++; if (ctl !== 4'b1100) begin errs++; $display("FAIL rst_busy: got %b want %b", ctl, 4'b1100); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL rst_async_ctl: got %b want %b", ctl, 4'b0000); end
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL rst_async_fwd: got %b want %b", fwd, 4'b0000); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    set_id(1, 8, 8, 1, 0, 10, 1, 0, 0);
    vecs++; if (ctl !== 4'b0000) begin errs++; $display("FAIL rst_no_stall: got %b want %b", ctl, 4'b0000); end
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (fwd !== 4'b0000) begin errs++; $display("FAIL rst_fwd: got %b want %b", fwd, 4'b0000); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_mem_fwd;
    test_imm;
    test_load_use;
    test_vmul;
    test_branch;
    test_load_vmul;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
